// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller.
// Holds the FSM state encoding used by serial_sub_ctrl.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_sub_bit_cell.sv
// Combinational one-bit full subtractor: d = a - b - bw_in.
// Ports: a, b, bw_in in; d (difference bit), bw_out (borrow) out.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = a ^ b ^ bw_in;
  assign bw_out = (~a & b) | (~a & bw_in) | (b & bw_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: start handshake in, LSB-first run, result handshake out.
// Ports: clk, reset (sync, active-high); start_valid/start_ready, a, b, borrow_in;
//   result_valid/result_ready, diff, borrow_out; busy; ovf only when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             busy,
  output logic             ovf
`else
  output logic             busy
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_sub_ctrl: WIDTH must be 2..32");
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bw_q;
  logic             d_bit;
  logic             bw_nxt;
  logic             accept;
  logic             last;
  logic             run;

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign run          = (state_q == S_RUN);
  assign busy         = run;
  assign accept       = start_valid & start_ready;
  assign last         = (cnt_q == LAST);
  assign diff         = diff_q;
  assign borrow_out   = bw_q;

  sub_bit_cell u_cell (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .bw_in  (bw_q),
    .d      (d_bit),
    .bw_out (bw_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)       state_d = S_RUN;
      S_RUN:  if (last)         state_d = S_DONE;
      S_DONE: if (result_ready) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Operands shift right so bit cnt always sits at index 0;
  // difference bits enter at the MSB and settle LSB-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bw_q   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      a_q    <= a;
      b_q    <= b;
      bw_q   <= borrow_in;
    end else if (run) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      bw_q   <= bw_nxt;
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      cnt_q  <= last ? '0 : cnt_q + ONE;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // MSBs are kept aside because the shift registers
  // have consumed them by the time the run ends.
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (run && last)
        ovf_q <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
